// File: rtl/qos_pkg.sv
// Shared QoS types: class count, request field widths, class index and request
// record. Also consumed by the DRR arbiter (drr_qos).
package qos_pkg;
  localparam int C     = 4;
  localparam int LEN_W = 12;
  localparam int TAG_W = 8;
  localparam int CLS_W = (C > 1) ? $clog2(C) : 1;

  typedef logic [CLS_W-1:0] cls_t;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [TAG_W-1:0] tag;
  } qos_req_t;
endpackage

// File: rtl/qos_class_fifo.sv
// Single-class FIFO with wrapping pointers, entry count and a registered head
// copy, so the arbiter-facing head never comes from the unreset storage array.
module qos_class_fifo #(
  parameter  int W     = 20,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int OW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [OW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == OW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    // DEPTH is a power of two, so pointer overflow is the wrap
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Head follows the read pointer; a push into an emptying/empty queue bypasses storage
    if (do_pop) begin
      if (cnt_q == OW'(1)) begin
        if (do_push) head_d = wdata;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end else if (empty && do_push) begin
      head_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  assign head  = head_q;
  assign count = cnt_q;
endmodule

// File: rtl/qos_class_queues.sv
// Per-class request queues feeding a DRR arbiter and popping to an L2 slice.
// Optional QOS_CLASSQ_DROP_CNT_EN: never backpressure, drop+count pushes to full classes.
module qos_class_queues
  import qos_pkg::*;
#(
  parameter  int C     = qos_pkg::C,
  parameter  int LEN_W = qos_pkg::LEN_W,
  parameter  int TAG_W = qos_pkg::TAG_W,
  parameter  int DEPTH = 8,
  localparam int CW    = (C > 1) ? $clog2(C) : 1,
  localparam int OW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CW-1:0]      in_class,
  input  logic [LEN_W-1:0]   in_len,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [C-1:0]       req_valid,
  output logic [C*LEN_W-1:0] req_len_flat,
  input  logic [C-1:0]       grant,
  input  logic               grant_valid,
  output logic               out_valid,
  output logic [CW-1:0]      out_class,
  output logic [LEN_W-1:0]   out_len,
  output logic [TAG_W-1:0]   out_tag,
  output logic [C*OW-1:0]    occupancy_flat,
  output logic               grant_err
`ifdef QOS_CLASSQ_DROP_CNT_EN
  , output logic [C*16-1:0]  drop_cnt_flat
`endif
);
  localparam int W = LEN_W + TAG_W;

  logic [C-1:0]         full, empty, push, pop;
  logic [C-1:0][W-1:0]  head;
  logic [C-1:0][OW-1:0] count;
  logic [CW:0]          cls_ext;
  logic                 cls_ok, cls_full, pop_any;
  logic [CW-1:0]        pop_idx;

  logic                 out_valid_q, out_valid_d;
  logic [CW-1:0]        out_class_q, out_class_d;
  logic [W-1:0]         out_ent_q, out_ent_d;
  logic                 grant_err_q, grant_err_d;

  always_comb begin
    cls_ext  = {1'b0, in_class};
    cls_ok   = (cls_ext < (CW+1)'(C));
    cls_full = cls_ok && full[in_class];
  end

`ifdef QOS_CLASSQ_DROP_CNT_EN
  assign in_ready = 1'b1;
`else
  // Uses registered fullness only: a same-cycle pop never makes room for this push
  assign in_ready = !cls_full;
`endif

  always_comb begin
    push    = '0;
    pop     = '0;
    pop_any = 1'b0;
    pop_idx = '0;
    for (int k = 0; k < C; k++) begin
      push[k] = in_valid && cls_ok && (cls_ext == (CW+1)'(k));
      // Lowest granted non-empty class wins, which also resolves malformed grants
      if (grant_valid && grant[k] && !empty[k] && !pop_any) begin
        pop[k]  = 1'b1;
        pop_any = 1'b1;
        pop_idx = CW'(k);
      end
    end
  end

  always_comb begin
    out_valid_d = pop_any;
    out_class_d = pop_any ? pop_idx : out_class_q;
    out_ent_d   = pop_any ? head[pop_idx] : out_ent_q;
    grant_err_d = grant_err_q
                | (grant_valid && (!$onehot(grant) || ((grant & ~empty) == '0)))
                | (in_valid && !cls_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_ent_q   <= '0;
      grant_err_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_ent_q   <= out_ent_d;
      grant_err_q <= grant_err_d;
    end
  end

  for (genvar k = 0; k < C; k++) begin : g_cls
    qos_class_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[k]),
      .pop     (pop[k]),
      .wdata   ({in_len, in_tag}),
      .head    (head[k]),
      .count   (count[k]),
      .full    (full[k]),
      .empty   (empty[k])
    );
    assign req_len_flat[k*LEN_W +: LEN_W] = head[k][W-1 -: LEN_W];
    assign occupancy_flat[k*OW +: OW]     = count[k];
  end

  assign req_valid = ~empty;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_len   = out_ent_q[W-1 -: LEN_W];
  assign out_tag   = out_ent_q[TAG_W-1:0];
  assign grant_err = grant_err_q;

`ifdef QOS_CLASSQ_DROP_CNT_EN
  logic [C-1:0][15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    for (int k = 0; k < C; k++) begin
      if (push[k] && full[k] && (drop_cnt_q[k] != 16'hffff))
        drop_cnt_d[k] = drop_cnt_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_flat = drop_cnt_q;
`endif
endmodule
